// File: rtl/cp0_exc_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | cp0_exc_ctrl_pkg : CP0 addresses, ExcCodes, Status bits, sequencer states   |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

package cp0_exc_ctrl_pkg;

  localparam logic [4:0] c_reg_badvaddr = 5'd8;
  localparam logic [4:0] c_reg_status   = 5'd12;
  localparam logic [4:0] c_reg_cause    = 5'd13;
  localparam logic [4:0] c_reg_epc      = 5'd14;

  localparam logic [4:0] c_exc_int = 5'd0;
  localparam logic [4:0] c_exc_sys = 5'd8;
  localparam logic [4:0] c_exc_ri  = 5'd10;
  localparam logic [4:0] c_exc_ov  = 5'd12;
  localparam logic [4:0] c_exc_tr  = 5'd13;

  localparam int          c_status_ie  = 0;
  localparam int          c_status_exl = 1;
  localparam logic [31:0] c_exl_mask   = 32'h0000_0002;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_EPC    = 3'd1,
    ST_W_CAUSE  = 3'd2,
    ST_W_STATUS = 3'd3,
    ST_W_BADV   = 3'd4,
    ST_REDIRECT = 3'd5
  } exc_state_e;

  // Delay-slot instructions report the branch that owns the slot.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd,
                                         input logic [31:0] step);
    return bd ? (pc - step) : pc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_exc_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | cp0_exc_ctrl_if : MEM request, CP0 state, CP0 write port and flush bundle   |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

interface cp0_exc_ctrl_if;
  logic        exc_valid_i;
  logic        exc_ready_o;
  logic        exc_eret_i;
  logic [4:0]  exc_code_i;
  logic [31:0] exc_pc_i;
  logic        exc_in_delay_i;
  logic [31:0] exc_badvaddr_i;
  logic [31:0] int_pc_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic        cp0_we_o;
  logic [4:0]  cp0_waddr_o;
  logic [31:0] cp0_wdata_o;
  logic        stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;

  modport master (
    output exc_valid_i, exc_eret_i, exc_code_i, exc_pc_i, exc_in_delay_i,
           exc_badvaddr_i, int_pc_i, status_i, cause_i, epc_i,
    input  exc_ready_o, cp0_we_o, cp0_waddr_o, cp0_wdata_o, stall_o, flush_o,
           new_pc_o
  );

  modport slave (
    input  exc_valid_i, exc_eret_i, exc_code_i, exc_pc_i, exc_in_delay_i,
           exc_badvaddr_i, int_pc_i, status_i, cause_i, epc_i,
    output exc_ready_o, cp0_we_o, cp0_waddr_o, cp0_wdata_o, stall_o, flush_o,
           new_pc_o
  );
endinterface

`default_nettype wire

// File: rtl/cp0_int_detect.sv
// +----------------------------------------------------------------------------+
// | cp0_int_detect : registered pending-interrupt qualifier (IM&IP, IE, !EXL)   |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module cp0_int_detect (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic [7:0] im,
  input  wire logic [7:0] ip,
  input  wire logic       ie,
  input  wire logic       exl,
  output logic            pending
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= 1'b0;
    end else begin
      pending <= (|(im & ip)) & ie & ~exl;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cp0_exc_ctrl.sv
// +----------------------------------------------------------------------------+
// | cp0_exc_ctrl : serialises EPC/Cause/Status(/BadVAddr) writes then flushes.  |
// | Optional W_BADV state: define CP0_EXC_BADVADDR_EN.  Revision 1.0            |
// +----------------------------------------------------------------------------+
`default_nettype none

module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
  parameter int unsigned PC_STEP    = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  cp0_exc_ctrl_if.slave   bus
);

  localparam logic [31:0] c_pc_step = 32'(PC_STEP);

  exc_state_e  r_state;
  exc_state_e  w_next;
  logic        w_int_pending;
  logic        w_idle;
  logic        w_take_exc;
  logic        w_take_int;

  logic [31:0] r_pc;
  logic [4:0]  r_code;
  logic        r_bd;
  logic        r_eret;
  logic [31:0] r_status;
  logic [25:0] r_cause_keep;

  logic        w_we;
  logic [4:0]  w_waddr;
  logic [31:0] w_wdata;
  logic        w_flush;
  logic [31:0] w_new_pc;

`ifdef CP0_EXC_BADVADDR_EN
  logic [31:0] r_badv;
  logic        r_is_int;
`else
  logic        unused_badvaddr;
  assign unused_badvaddr = ^bus.exc_badvaddr_i;
`endif

  cp0_int_detect u_int_detect (
    .clk     (clk),
    .rst     (rst),
    .im      (bus.status_i[15:8]),
    .ip      (bus.cause_i[15:8]),
    .ie      (bus.status_i[c_status_ie]),
    .exl     (bus.status_i[c_status_exl]),
    .pending (w_int_pending)
  );

  assign w_idle     = (r_state == ST_IDLE);
  assign w_take_exc = w_idle & bus.exc_valid_i;
  // A simultaneous MEM request wins; the interrupt remains pending behind it.
  assign w_take_int = w_idle & ~bus.exc_valid_i & w_int_pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_pc         <= '0;
      r_code       <= '0;
      r_bd         <= 1'b0;
      r_eret       <= 1'b0;
      r_status     <= '0;
      r_cause_keep <= '0;
`ifdef CP0_EXC_BADVADDR_EN
      r_badv       <= '0;
      r_is_int     <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_take_exc || w_take_int) begin
        r_pc         <= w_take_exc ? bus.exc_pc_i : bus.int_pc_i;
        r_code       <= w_take_exc ? bus.exc_code_i : c_exc_int;
        r_bd         <= w_take_exc & bus.exc_in_delay_i;
        r_eret       <= w_take_exc & bus.exc_eret_i;
        r_status     <= bus.status_i;
        r_cause_keep <= {bus.cause_i[30:7], bus.cause_i[1:0]};
`ifdef CP0_EXC_BADVADDR_EN
        r_badv       <= bus.exc_badvaddr_i;
        r_is_int     <= w_take_int;
`endif
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    w_we     = 1'b0;
    w_waddr  = '0;
    w_wdata  = '0;
    w_flush  = 1'b0;
    w_new_pc = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_take_exc) begin
          w_next = bus.exc_eret_i ? ST_W_STATUS : ST_W_EPC;
        end else if (w_take_int) begin
          w_next = ST_W_EPC;
        end
      end
      ST_W_EPC: begin
        w_we    = 1'b1;
        w_waddr = c_reg_epc;
        w_wdata = epc_of(r_pc, r_bd, c_pc_step);
        w_next  = ST_W_CAUSE;
      end
      ST_W_CAUSE: begin
        w_we    = 1'b1;
        w_waddr = c_reg_cause;
        w_wdata = {r_bd, r_cause_keep[25:2], r_code, r_cause_keep[1:0]};
        w_next  = ST_W_STATUS;
      end
      ST_W_STATUS: begin
        w_we    = 1'b1;
        w_waddr = c_reg_status;
        w_wdata = r_eret ? (r_status & ~c_exl_mask) : (r_status | c_exl_mask);
`ifdef CP0_EXC_BADVADDR_EN
        w_next  = (r_eret || r_is_int) ? ST_REDIRECT : ST_W_BADV;
`else
        w_next  = ST_REDIRECT;
`endif
      end
`ifdef CP0_EXC_BADVADDR_EN
      ST_W_BADV: begin
        w_we    = 1'b1;
        w_waddr = c_reg_badvaddr;
        w_wdata = r_badv;
        w_next  = ST_REDIRECT;
      end
`endif
      ST_REDIRECT: begin
        w_flush  = 1'b1;
        w_new_pc = r_eret ? bus.epc_i : EXC_VECTOR;
        w_next   = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign bus.exc_ready_o = w_idle;
  assign bus.stall_o     = ~w_idle;
  assign bus.cp0_we_o    = w_we;
  assign bus.cp0_waddr_o = w_waddr;
  assign bus.cp0_wdata_o = w_wdata;
  assign bus.flush_o     = w_flush;
  assign bus.new_pc_o    = w_new_pc;

endmodule

`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_cp0_exc_ctrl : directed and randomized checks of cp0_exc_ctrl against a  |
// | cycle-sequence reference built from the architectural update rules. Rev 1.0 |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cp0_exc_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cp0_exc_ctrl_if bus ();

  cp0_exc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural cp0_reg: Cause only accepts BD and ExcCode from the write port.
  logic [31:0] m_status, m_cause, m_epc, m_badv;
  assign bus.status_i = m_status;
  assign bus.cause_i  = m_cause;
  assign bus.epc_i    = m_epc;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [72:0] obs_vec;
  logic [72:0] exp_q[$];

  // {we, addr, data, flush, new_pc, stall, ready}
  function automatic logic [72:0] busy(input logic we, input logic [4:0] a,
                                       input logic [31:0] d, input logic fl,
                                       input logic [31:0] npc);
    return {we, a, d, fl, npc, 1'b1, 1'b0};
  endfunction

  function automatic logic [72:0] idle_vec();
    return {1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1};
  endfunction

  // Expected per-cycle outputs after acceptance, from the current register model.
  function automatic void build_seq(input bit eret, input bit is_int, input logic [4:0] code,
                                    input logic [31:0] pc, input bit bd,
                                    input logic [31:0] badv);
    logic [31:0] cause_new;
    exp_q.delete();
    if (eret) begin
      exp_q.push_back(busy(1'b1, 5'd12, m_status & ~32'h2, 1'b0, 32'd0));
      exp_q.push_back(busy(1'b0, 5'd0, 32'd0, 1'b1, m_epc));
      return;
    end
    cause_new = (m_cause & 32'h7FFF_FF83) | (bd ? 32'h8000_0000 : 32'd0) | (32'(code) << 2);
    exp_q.push_back(busy(1'b1, 5'd14, bd ? pc - 32'd4 : pc, 1'b0, 32'd0));
    exp_q.push_back(busy(1'b1, 5'd13, cause_new, 1'b0, 32'd0));
    exp_q.push_back(busy(1'b1, 5'd12, m_status | 32'h2, 1'b0, 32'd0));
`ifdef CP0_EXC_BADVADDR_EN
    if (!is_int) exp_q.push_back(busy(1'b1, 5'd8, badv, 1'b0, 32'd0));
`else
    if (is_int && badv === 32'hx) exp_q.delete();
`endif
    exp_q.push_back(busy(1'b0, 5'd0, 32'd0, 1'b1, 32'h0000_0040));
  endfunction

  // One clock: sample outputs at negedge, then commit any CP0 write after the edge.
  task automatic cycle();
    logic we;
    logic [4:0] a;
    logic [31:0] d;
    @(negedge clk);
    we = bus.cp0_we_o;
    a  = bus.cp0_waddr_o;
    d  = bus.cp0_wdata_o;
    obs_vec = {we, we ? a : 5'd0, we ? d : 32'd0, bus.flush_o,
               bus.flush_o ? bus.new_pc_o : 32'd0, bus.stall_o, bus.exc_ready_o};
    @(posedge clk);
    #1;
    if (rst === 1'b1 && we === 1'b1) begin
      case (a)
        5'd8:    m_badv   = d;
        5'd12:   m_status = d;
        5'd13:   m_cause  = (m_cause & ~32'h8000_007C) | (d & 32'h8000_007C);
        5'd14:   m_epc    = d;
        default: ;
      endcase
    end
  endtask

  task automatic request(input bit eret, input logic [4:0] code, input logic [31:0] pc,
                         input bit bd, input logic [31:0] badv);
    bus.exc_valid_i    = 1'b1;
    bus.exc_eret_i     = eret;
    bus.exc_code_i     = code;
    bus.exc_pc_i       = pc;
    bus.exc_in_delay_i = bd;
    bus.exc_badvaddr_i = badv;
  endtask

  // Request fields change while the block is busy; they must be ignored.
  task automatic scramble();
    bus.exc_eret_i     = 1'($urandom);
    bus.exc_code_i     = 5'($urandom);
    bus.exc_pc_i       = $urandom;
    bus.exc_in_delay_i = 1'($urandom);
    bus.exc_badvaddr_i = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_cmp++;
      if (obs_vec !== idle_vec()) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %h, expected %h", i, obs_vec, idle_vec());
      end
    end
    rst = 1'b1;
    cycle();
    n_cmp++;
    if (obs_vec !== idle_vec()) begin
      n_fail++;
      $display("FAIL reset_release: got %h, expected %h", obs_vec, idle_vec());
    end
  endtask

  task automatic test_sys();
    m_status = 32'h1000_0001;
    m_cause  = 32'd0;
    request(1'b0, 5'd8, 32'h0000_0100, 1'b0, 32'hDEAD_0100);
    cycle();
    n_cmp++;
    if (obs_vec !== idle_vec()) begin
      n_fail++;
      $display("FAIL sys_accept: got %h, expected %h", obs_vec, idle_vec());
    end
    build_seq(1'b0, 1'b0, 5'd8, 32'h0000_0100, 1'b0, 32'hDEAD_0100);
    foreach (exp_q[i]) begin
      if (i == exp_q.size() - 1) bus.exc_valid_i = 1'b0; else scramble();
      cycle();
      n_cmp++;
      if (obs_vec !== exp_q[i]) begin
        n_fail++;
        $display("FAIL sys[%0d]: got %h, expected %h", i, obs_vec, exp_q[i]);
      end
    end
    n_cmp++;
    if (m_status !== 32'h1000_0003 || m_epc !== 32'h100 || m_cause !== 32'h20) begin
      n_fail++;
      $display("FAIL sys_regs: got st=%h epc=%h cause=%h, expected 10000003 00000100 00000020",
               m_status, m_epc, m_cause);
    end
    cycle();
    n_cmp++;
    if (obs_vec !== idle_vec()) begin
      n_fail++;
      $display("FAIL sys_after: got %h, expected %h", obs_vec, idle_vec());
    end
  endtask

  task automatic test_delay_slot();
    logic [31:0] pcs [2];
    logic [4:0]  codes [2];
    pcs[0] = 32'h0;  codes[0] = 5'd13;
    pcs[1] = 32'h204; codes[1] = 5'd12;
    for (int k = 0; k < 2; k++) begin
      m_status = 32'h1000_0001;
      request(1'b0, codes[k], pcs[k], 1'b1, 32'h0BAD_0000 + 32'(k));
      cycle();
      n_cmp++;
      if (obs_vec !== idle_vec()) begin
        n_fail++;
        $display("FAIL bd_accept[%0d]: got %h, expected %h", k, obs_vec, idle_vec());
      end
      build_seq(1'b0, 1'b0, codes[k], pcs[k], 1'b1, 32'h0BAD_0000 + 32'(k));
      foreach (exp_q[i]) begin
        if (i == exp_q.size() - 1) bus.exc_valid_i = 1'b0; else scramble();
        cycle();
        n_cmp++;
        if (obs_vec !== exp_q[i]) begin
          n_fail++;
          $display("FAIL bd%0d[%0d]: got %h, expected %h", k, i, obs_vec, exp_q[i]);
        end
      end
      n_cmp++;
      if (m_epc !== (k == 0 ? 32'hFFFF_FFFC : 32'h200) || m_cause[31] !== 1'b1) begin
        n_fail++;
        $display("FAIL bd_regs[%0d]: got epc=%h bd=%b, expected epc=%h bd=1", k, m_epc,
                 m_cause[31], (k == 0 ? 32'hFFFF_FFFC : 32'h200));
      end
    end
  endtask

  task automatic test_eret();
    m_status = 32'h1000_0003;
    m_epc    = 32'h0000_0200;
    request(1'b1, 5'd0, 32'h0000_0300, 1'b0, 32'd0);
    cycle();
    n_cmp++;
    if (obs_vec !== idle_vec()) begin
      n_fail++;
      $display("FAIL eret_accept: got %h, expected %h", obs_vec, idle_vec());
    end
    build_seq(1'b1, 1'b0, 5'd0, 32'h0000_0300, 1'b0, 32'd0);
    foreach (exp_q[i]) begin
      if (i == exp_q.size() - 1) bus.exc_valid_i = 1'b0; else scramble();
      cycle();
      n_cmp++;
      if (obs_vec !== exp_q[i]) begin
        n_fail++;
        $display("FAIL eret[%0d]: got %h, expected %h", i, obs_vec, exp_q[i]);
      end
    end
    n_cmp++;
    if (m_status !== 32'h1000_0001) begin
      n_fail++;
      $display("FAIL eret_status: got %h, expected 10000001", m_status);
    end
  endtask

  task automatic test_interrupt();
    bus.int_pc_i = 32'h0000_0300;
    m_status = 32'h1000_0401;
    m_cause  = 32'h0000_0400;
    // Qualifier is registered: nothing happens in the cycle the condition appears.
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_cmp++;
      if (obs_vec !== idle_vec()) begin
        n_fail++;
        $display("FAIL int_wait[%0d]: got %h, expected %h", i, obs_vec, idle_vec());
      end
    end
    build_seq(1'b0, 1'b1, 5'd0, 32'h0000_0300, 1'b0, 32'd0);
    foreach (exp_q[i]) begin
      cycle();
      n_cmp++;
      if (obs_vec !== exp_q[i]) begin
        n_fail++;
        $display("FAIL int[%0d]: got %h, expected %h", i, obs_vec, exp_q[i]);
      end
    end
    n_cmp++;
    if (m_epc !== 32'h300 || m_cause[6:2] !== 5'd0 || m_status !== 32'h1000_0403) begin
      n_fail++;
      $display("FAIL int_regs: got epc=%h code=%0d st=%h, expected 300 0 10000403",
               m_epc, m_cause[6:2], m_status);
    end
    m_status = 32'h1000_0403;
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_cmp++;
      if (obs_vec !== idle_vec()) begin
        n_fail++;
        $display("FAIL int_exl[%0d]: got %h, expected %h", i, obs_vec, idle_vec());
      end
    end
    m_cause = 32'd0;
    cycle();
  endtask

  task automatic test_same_cycle();
    m_status = 32'h1000_0401;
    m_cause  = 32'h0000_0400;
    bus.int_pc_i = 32'h0000_0600;
    cycle();
    n_cmp++;
    if (obs_vec !== idle_vec()) begin
      n_fail++;
      $display("FAIL same_pre: got %h, expected %h", obs_vec, idle_vec());
    end
    request(1'b0, 5'd8, 32'h0000_0500, 1'b0, 32'h0000_5555);
    cycle();
    build_seq(1'b0, 1'b0, 5'd8, 32'h0000_0500, 1'b0, 32'h0000_5555);
    foreach (exp_q[i]) begin
      if (i == exp_q.size() - 1) bus.exc_valid_i = 1'b0; else scramble();
      cycle();
      n_cmp++;
      if (obs_vec !== exp_q[i]) begin
        n_fail++;
        $display("FAIL same_exc[%0d]: got %h, expected %h", i, obs_vec, exp_q[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if (obs_vec !== idle_vec()) begin
        n_fail++;
        $display("FAIL same_hold[%0d]: got %h, expected %h", i, obs_vec, idle_vec());
      end
    end
    request(1'b1, 5'd0, 32'd0, 1'b0, 32'd0);
    cycle();
    build_seq(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    foreach (exp_q[i]) begin
      if (i == exp_q.size() - 1) bus.exc_valid_i = 1'b0; else scramble();
      cycle();
      n_cmp++;
      if (obs_vec !== exp_q[i]) begin
        n_fail++;
        $display("FAIL same_eret[%0d]: got %h, expected %h", i, obs_vec, exp_q[i]);
      end
    end
    // EXL is clear again, so the held interrupt is accepted straight away.
    cycle();
    n_cmp++;
    if (obs_vec !== idle_vec()) begin
      n_fail++;
      $display("FAIL same_int_accept: got %h, expected %h", obs_vec, idle_vec());
    end
    build_seq(1'b0, 1'b1, 5'd0, 32'h0000_0600, 1'b0, 32'd0);
    foreach (exp_q[i]) begin
      cycle();
      n_cmp++;
      if (obs_vec !== exp_q[i]) begin
        n_fail++;
        $display("FAIL same_int[%0d]: got %h, expected %h", i, obs_vec, exp_q[i]);
      end
    end
    m_cause = 32'd0;
    cycle();
  endtask

  task automatic test_reset_mid();
    m_status = 32'h1000_0001;
    m_cause  = 32'd0;
    request(1'b0, 5'd8, 32'h0000_0700, 1'b0, 32'h0000_7777);
    cycle();
    cycle();
    n_cmp++;
    if (obs_vec !== busy(1'b1, 5'd14, 32'h700, 1'b0, 32'd0)) begin
      n_fail++;
      $display("FAIL rstmid_epc: got %h, expected %h", obs_vec,
               busy(1'b1, 5'd14, 32'h700, 1'b0, 32'd0));
    end
    rst = 1'b0;
    bus.exc_valid_i = 1'b0;
    cycle();
    n_cmp++;
    if (obs_vec !== idle_vec()) begin
      n_fail++;
      $display("FAIL rstmid_reset: got %h, expected %h", obs_vec, idle_vec());
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_cmp++;
      if (obs_vec !== idle_vec()) begin
        n_fail++;
        $display("FAIL rstmid_after[%0d]: got %h, expected %h", i, obs_vec, idle_vec());
      end
    end
    n_cmp++;
    if (m_epc !== 32'h700 || m_cause !== 32'd0) begin
      n_fail++;
      $display("FAIL rstmid_regs: got epc=%h cause=%h, expected 00000700 00000000",
               m_epc, m_cause);
    end
  endtask

  task automatic test_random();
    logic [4:0]  codes [4];
    logic [4:0]  code;
    logic [31:0] pc, badv;
    bit          eret, bd;
    codes[0] = 5'd8; codes[1] = 5'd10; codes[2] = 5'd12; codes[3] = 5'd13;
    for (int n = 0; n < 24; n++) begin
      m_status = $urandom;
      m_cause  = $urandom & 32'hFFFF_00FF;
      m_epc    = $urandom;
      eret     = 1'($urandom);
      bd       = 1'($urandom);
      code     = codes[$urandom_range(0, 3)];
      pc       = $urandom;
      badv     = $urandom;
      cycle();
      n_cmp++;
      if (obs_vec !== idle_vec()) begin
        n_fail++;
        $display("FAIL rnd_idle[%0d]: got %h, expected %h", n, obs_vec, idle_vec());
      end
      request(eret, code, pc, bd, badv);
      cycle();
      build_seq(eret, 1'b0, code, pc, bd, badv);
      foreach (exp_q[i]) begin
        if (i == exp_q.size() - 1) bus.exc_valid_i = 1'b0; else scramble();
        cycle();
        n_cmp++;
        if (obs_vec !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rnd%0d[%0d]: got %h, expected %h", n, i, obs_vec, exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    rst                = 1'b0;
    m_status           = 32'd0;
    m_cause            = 32'd0;
    m_epc              = 32'd0;
    m_badv             = 32'd0;
    bus.exc_valid_i    = 1'b0;
    bus.exc_eret_i     = 1'b0;
    bus.exc_code_i     = 5'd0;
    bus.exc_pc_i       = 32'd0;
    bus.exc_in_delay_i = 1'b0;
    bus.exc_badvaddr_i = 32'd0;
    bus.int_pc_i       = 32'd0;
    test_reset();
    test_sys();
    test_delay_slot();
    test_eret();
    test_interrupt();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected $finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
